// File: rtl/bus_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_reg_pkg
// Purpose  : Shared constants, FSM encoding and request record for the
//            bus register responder.
// Revision : 1.0 - initial release
// ============================================================================
package bus_reg_pkg;

   localparam int c_REG_W = 32;
   localparam int c_NBYTE = 4;
   localparam int c_IDX_W = 6;

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_WAIT = 2'd1;
   localparam logic [1:0] c_RESP = 2'd2;

   typedef struct packed {
      logic                  we;
      logic                  hit;
      logic [c_IDX_W-1:0]    idx;
      logic [c_NBYTE-1:0]    sel;
      logic [c_REG_W-1:0]    dat;
   } req_t;

endpackage
`default_nettype wire

// File: rtl/bus_reg_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_reg_responder_if
// Purpose  : Single-beat stb/ack/err register bus between CPU and responder.
// Revision : 1.0 - initial release
// ============================================================================
interface bus_reg_responder_if;

   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [3:0]  sel;
   logic [31:0] dat_i;
   logic [31:0] dat_o;
   logic        ack;
   logic        err;

   modport master (
      output stb, we, adr, sel, dat_i,
      input  dat_o, ack, err
   );

   modport slave (
      input  stb, we, adr, sel, dat_i,
      output dat_o, ack, err
   );

endinterface
`default_nettype wire

// File: rtl/bus_reg_responder_reg32_be.sv
`default_nettype none
// ============================================================================
// Module   : reg32_be
// Purpose  : 32-bit register with per-byte bus enables and a full-word
//            hardware load; bus-enabled bytes win over the hardware word.
// Revision : 1.0 - initial release
// ============================================================================
module reg32_be
   import bus_reg_pkg::*;
#(
   parameter logic [31:0] RESET_VAL = 32'h0
) (
   input  wire logic                clk,
   input  wire logic                rst,
   input  wire logic [c_NBYTE-1:0]  i_wr_be,
   input  wire logic [c_REG_W-1:0]  i_wr_d,
   input  wire logic                i_hw_we,
   input  wire logic [c_REG_W-1:0]  i_hw_d,
   output logic [c_REG_W-1:0]       o_q
);

   logic [c_REG_W-1:0] r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= RESET_VAL;
      end else begin
         for (int i = 0; i < c_NBYTE; i++) begin
            if (i_wr_be[i])
               r_q[8*i +: 8] <= i_wr_d[8*i +: 8];
            else if (i_hw_we)
               r_q[8*i +: 8] <= i_hw_d[8*i +: 8];
         end
      end
   end

   assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/bus_reg_responder.sv
`default_nettype none
// ============================================================================
// Module   : bus_reg_responder
// Purpose  : Bus responder for NREG 32-bit control/status registers with
//            hardware load path. Define BUS_REG_WAIT_EN for an extra WAIT
//            cycle between request and response.
// Revision : 1.0 - initial release
// ============================================================================
module bus_reg_responder
   import bus_reg_pkg::*;
#(
   parameter int          NREG      = 8,
   parameter logic [31:0] BASE      = 32'hFFFF_0000,
   parameter logic [31:0] RESET_VAL = 32'h0
) (
   input  wire logic                    clk,
   input  wire logic                    rst,
   bus_reg_responder_if.slave           bus,
   input  wire logic [NREG-1:0]         hw_we,
   input  wire logic [NREG*c_REG_W-1:0] hw_d,
   output logic [NREG*c_REG_W-1:0]      q
);

   localparam int c_IW = $clog2(NREG);

   logic [1:0]         r_state;
   logic               r_ack;
   logic               r_err;
   logic [c_REG_W-1:0] r_dat_o;
   req_t               w_live;
   req_t               w_cmt;
   logic               w_enter_resp;
   logic [c_REG_W-1:0] w_q [NREG];

   assign w_live.we  = bus.we;
   assign w_live.hit = (bus.adr[31:c_IW+2] == BASE[31:c_IW+2]) &&
                       (bus.adr[1:0] == 2'b00);
   assign w_live.idx = c_IDX_W'(bus.adr[c_IW+1:2]);
   assign w_live.sel = bus.sel;
   assign w_live.dat = bus.dat_i;

`ifdef BUS_REG_WAIT_EN
   // Request is held in a register so the commit sees stable values in WAIT.
   req_t r_req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_req <= '0;
      else if (r_state == c_IDLE && bus.stb)
         r_req <= w_live;
   end

   assign w_cmt        = r_req;
   assign w_enter_resp = (r_state == c_WAIT);
`else
   assign w_cmt        = w_live;
   assign w_enter_resp = (r_state == c_IDLE) && bus.stb;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_IDLE;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_dat_o <= '0;
      end else begin
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_dat_o <= '0;
         case (r_state)
            c_IDLE: begin
               if (bus.stb) begin
`ifdef BUS_REG_WAIT_EN
                  r_state <= c_WAIT;
`else
                  r_state <= c_RESP;
`endif
               end
            end
            c_WAIT:  r_state <= c_RESP;
            c_RESP:  r_state <= c_IDLE;
            default: r_state <= c_IDLE;
         endcase
         // Read data is sampled before any same-edge hardware load lands.
         if (w_enter_resp) begin
            r_ack   <= w_cmt.hit;
            r_err   <= ~w_cmt.hit;
            r_dat_o <= (w_cmt.hit && !w_cmt.we) ? w_q[w_cmt.idx[c_IW-1:0]] : '0;
         end
      end
   end

   for (genvar k = 0; k < NREG; k++) begin : g_reg
      logic [c_NBYTE-1:0] w_be;

      assign w_be = (w_enter_resp && w_cmt.we && w_cmt.hit &&
                     (w_cmt.idx == c_IDX_W'(k))) ? w_cmt.sel : '0;

      reg32_be #(
         .RESET_VAL (RESET_VAL)
      ) u_reg (
         .clk     (clk),
         .rst     (rst),
         .i_wr_be (w_be),
         .i_wr_d  (w_cmt.dat),
         .i_hw_we (hw_we[k]),
         .i_hw_d  (hw_d[c_REG_W*k +: c_REG_W]),
         .o_q     (w_q[k])
      );

      assign q[c_REG_W*k +: c_REG_W] = w_q[k];
   end

   assign bus.ack   = r_ack;
   assign bus.err   = r_err;
   assign bus.dat_o = r_dat_o;

endmodule
`default_nettype wire

// File: tb/tb_bus_reg_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_reg_responder
// Purpose  : Self-checking bench for bus_reg_responder against a register
//            array model; directed cases followed by random transfers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_reg_responder;

   localparam int          NREG      = 8;
   localparam logic [31:0] BASE      = 32'hFFFF_0000;
   localparam logic [31:0] RESET_VAL = 32'h0;
`ifdef BUS_REG_WAIT_EN
   localparam int          LAT       = 2;
`else
   localparam int          LAT       = 1;
`endif

   logic                 clk;
   logic                 rst;
   logic [NREG-1:0]      hw_we;
   logic [NREG*32-1:0]   hw_d;
   logic [NREG*32-1:0]   q;

   bus_reg_responder_if bif ();

   bus_reg_responder #(
      .NREG      (NREG),
      .BASE      (BASE),
      .RESET_VAL (RESET_VAL)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bif.slave),
      .hw_we (hw_we),
      .hw_d  (hw_d),
      .q     (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] mdl [NREG];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_q(input string tag);
      for (int k = 0; k < NREG; k++)
         check_eq($sformatf("%s_q%0d", tag, k), q[32*k +: 32], mdl[k]);
   endtask

   task automatic reset_model();
      for (int k = 0; k < NREG; k++) mdl[k] = RESET_VAL;
   endtask

   // Drives one transfer; hwm/hwd are presented on the edge that commits it.
   task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input logic [NREG-1:0] hwm,
                       input logic [NREG*32-1:0] hwd,
                       output logic [31:0] rdat, output logic got_ack,
                       output logic got_err, output int lat);
      bif.stb = 1'b1; bif.we = w; bif.adr = a; bif.sel = s; bif.dat_i = d;
      lat = 0; got_ack = 1'b0; got_err = 1'b0; rdat = '0;
      while (lat < 10 && !got_ack && !got_err) begin
         if (lat == LAT-1) begin hw_we = hwm; hw_d = hwd; end
         else hw_we = '0;
         @(posedge clk); #1;
         lat++;
         hw_we   = '0;
         got_ack = bif.ack;
         got_err = bif.err;
         rdat    = bif.dat_o;
         if (got_ack && got_err) check_eq("ack_and_err", 32'(got_ack & got_err), 32'd0);
      end
      bif.stb = 1'b0; bif.we = 1'b0; bif.sel = '0;
      @(posedge clk); #1;
      check_eq("one_cycle_resp", {bif.ack, bif.err, 30'd0}, 32'd0);
      check_eq("dat_o_idle", bif.dat_o, 32'd0);
   endtask

   // Transfer checked against the model; the model decides hit/index arithmetically.
   task automatic run_xfer(input string tag, input logic w, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] d,
                           input logic [NREG-1:0] hwm, input logic [NREG*32-1:0] hwd);
      longint      ua, ub;
      logic        hit;
      int          idx;
      logic [31:0] exp_rd, rdat;
      logic        ga, ge;
      int          lat;
      ua  = longint'(a);
      ub  = longint'(BASE);
      hit = (ua >= ub) && (ua < ub + NREG*4) && (ua % 4 == 0);
      idx = hit ? int'((ua - ub) / 4) : 0;
      exp_rd = (hit && !w) ? mdl[idx] : 32'h0;
      for (int k = 0; k < NREG; k++)
         if (hwm[k]) mdl[k] = hwd[32*k +: 32];
      if (hit && w)
         for (int b = 0; b < 4; b++)
            if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
      xfer(w, a, s, d, hwm, hwd, rdat, ga, ge, lat);
      check_eq({tag, "_lat"}, 32'(lat), 32'(LAT));
      check_eq({tag, "_ack"}, 32'(ga), 32'(hit));
      check_eq({tag, "_err"}, 32'(ge), 32'(!hit));
      check_eq({tag, "_rdat"}, rdat, exp_rd);
      check_q(tag);
   endtask

   initial begin
      logic [NREG*32-1:0] hwd;
      logic [NREG-1:0]    hwm;
      logic [31:0]        a, d;
      int                 r, idx, nack, cyc;
      int                 t_ack [3];

      rst = 1'b1; hw_we = '0; hw_d = '0;
      bif.stb = 1'b0; bif.we = 1'b0; bif.adr = '0; bif.sel = '0; bif.dat_i = '0;
      reset_model();
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_ack", 32'(bif.ack), 32'd0);
      check_eq("rst_err", 32'(bif.err), 32'd0);
      check_eq("rst_dat_o", bif.dat_o, 32'd0);
      check_q("rst");
      rst = 1'b0;
      @(posedge clk); #1;

      run_xfer("rd3", 1'b0, BASE + 32'd12, 4'h0, 32'h0, '0, '0);
      run_xfer("wr1_full", 1'b1, BASE + 32'd4, 4'hF, 32'h1234_5678, '0, '0);
      run_xfer("wr1_be", 1'b1, BASE + 32'd4, 4'b0011, 32'hDEAD_BEEF, '0, '0);
      check_eq("word1_merged", q[63:32], 32'h1234_BEEF);
      run_xfer("rd1", 1'b0, BASE + 32'd4, 4'h0, 32'h0, '0, '0);
      run_xfer("miss_hi", 1'b1, BASE + 32'd32, 4'hF, 32'hFFFF_FFFF, '0, '0);
      run_xfer("misalign", 1'b0, BASE + 32'd2, 4'hF, 32'h0, '0, '0);
      run_xfer("sel0", 1'b1, BASE + 32'd4, 4'h0, 32'h0BAD_0BAD, '0, '0);

      hwd = '0; hwd[95:64] = 32'hAAAA_AAAA;
      run_xfer("hw_collide", 1'b1, BASE + 32'd8, 4'b1000, 32'h5555_5555, 8'b0000_0100, hwd);
      check_eq("word2_merged", q[95:64], 32'h55AA_AAAA);

      for (int n = 0; n < 60; n++) begin
         r   = int'($urandom_range(0, 9));
         idx = int'($urandom_range(0, NREG-1));
         if (r < 7)       a = BASE + 32'(idx*4);
         else if (r == 7) a = BASE + 32'(idx*4) + 32'($urandom_range(1, 3));
         else if (r == 8) a = BASE + 32'(NREG*4) + 32'($urandom_range(0, 15) * 4);
         else             a = $urandom & 32'hFFFF_FFFC;
         d = $urandom;
         for (int k = 0; k < NREG; k++) hwd[32*k +: 32] = $urandom;
         hwm = ($urandom_range(0, 2) == 0) ? NREG'($urandom) : '0;
         run_xfer($sformatf("rnd%0d", n), 1'($urandom), a, 4'($urandom), d, hwm, hwd);
      end

      // Reset lands while a write is pending its commit edge.
      run_xfer("pre_rst_wr", 1'b1, BASE + 32'd20, 4'hF, 32'hC0FF_EE11, '0, '0);
      bif.stb = 1'b1; bif.we = 1'b1; bif.adr = BASE + 32'd20;
      bif.sel = 4'hF; bif.dat_i = 32'h1357_9BDF;
      repeat (LAT-1) begin @(posedge clk); #1; end
      rst = 1'b1;
      #2;
      @(posedge clk); #1;
      check_eq("midrst_ack", 32'(bif.ack), 32'd0);
      check_eq("midrst_err", 32'(bif.err), 32'd0);
      bif.stb = 1'b0; bif.we = 1'b0; bif.sel = '0;
      #2 rst = 1'b0;
      reset_model();
      @(posedge clk); #1;
      check_eq("postrst_ack", 32'(bif.ack), 32'd0);
      check_q("midrst");
      run_xfer("postrst_rd5", 1'b0, BASE + 32'd20, 4'h0, 32'h0, '0, '0);

      run_xfer("wr0", 1'b1, BASE, 4'hF, 32'h0F1E_2D3C, '0, '0);
      bif.stb = 1'b1; bif.we = 1'b0; bif.adr = BASE; bif.sel = '0;
      nack = 0; cyc = 0;
      while (cyc < 20 && nack < 3) begin
         @(posedge clk); #1;
         cyc++;
         if (bif.ack) begin
            t_ack[nack] = cyc;
            check_eq("b2b_rdat", bif.dat_o, mdl[0]);
            nack++;
         end
      end
      bif.stb = 1'b0;
      check_eq("b2b_count", 32'(nack), 32'd3);
      if (nack == 3) begin
         check_eq("b2b_first", 32'(t_ack[0]), 32'(LAT));
         check_eq("b2b_gap1", 32'(t_ack[1] - t_ack[0]), 32'(LAT + 1));
         check_eq("b2b_gap2", 32'(t_ack[2] - t_ack[1]), 32'(LAT + 1));
      end
      @(posedge clk); #1;
      check_eq("b2b_done", 32'(bif.ack), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
